// File: rtl/pes_piso_stream.sv
// Parallel-in/serial-out streamer: valid/ready word intake, selectable bit order,
// CLK_DIV clocks per bit, gapless back-to-back frames. Optional parity bit via PISO_PARITY_EN.
module pes_piso_stream #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int CLK_DIV    = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(FLEN + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   if (WIDTH < 2 || CLK_DIV < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("pes_piso_stream: illegal parameter value");
   end

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] ordered;
   logic [FLEN-1:0]  load_frame;
   logic [FLEN-1:0]  frame_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic             div_term;
   logic             last_bit;
   logic             accept;

   // The frame is always sent from the top of frame_reg, so bit order is fixed at load time.
   always_comb begin
      ordered = data_in;
      if (MSB_FIRST == 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            ordered[i] = data_in[WIDTH-1-i];
         end
      end
   end

`ifdef PISO_PARITY_EN
   logic parity_bit;
   assign parity_bit = (^data_in) ^ (PARITY_ODD != 0);
   assign load_frame = {ordered, parity_bit};
`else
   assign load_frame = ordered;
`endif

   assign div_term = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit = (bit_cnt == CNT_W'(FLEN - 1));
   assign accept   = in_valid && in_ready;
   assign ser_out  = frame_reg[FLEN-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A new word is only taken in IDLE or in the very last clock of the final bit.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      ser_valid  = 1'b0;
      ser_first  = 1'b0;
      ser_last   = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            busy      = 1'b1;
            ser_first = (bit_cnt == '0);
            ser_last  = last_bit;
            in_ready  = last_bit && div_term;
            if (last_bit && div_term && !in_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // frame_reg is zeroed when a frame ends so ser_out idles low.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_reg <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
      end else if (accept) begin
         frame_reg <= load_frame;
         bit_cnt   <= '0;
         div_cnt   <= '0;
      end else if (state == SHIFT) begin
         if (div_term) begin
            div_cnt <= '0;
            if (last_bit) begin
               frame_reg <= '0;
               bit_cnt   <= '0;
            end else begin
               frame_reg <= {frame_reg[FLEN-2:0], 1'b0};
               bit_cnt   <= bit_cnt + CNT_W'(1);
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: doc/pes_piso_stream.md
Name: pes_piso_stream

Overview:
Parametrised parallel-in/serial-out shifter and the successor to the fixed 4-bit load/shift PISO. Accepts WIDTH-bit words over a valid/ready handshake and serialises them with selectable bit order and programmable bit period. Supports gapless back-to-back frames and emits frame markers. Sits between a parallel producer (register bank or FIFO) and a single-wire serial link or downstream deserialiser.

Parameters:
WIDTH, 8, data word width in bits; must be at least 2
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
CLK_DIV, 1, clocks per serial bit; must be at least 1
PARITY_ODD, 0, parity sense; used only when PISO_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word
in_valid  input  1  data_in is valid
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a frame bit
ser_first  output  1  current bit is the first bit of the frame
ser_last  output  1  current bit is the final bit of the frame
busy  output  1  a frame is in progress

Behaviour:
- Reset (rst=1 at a rising edge): ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, in_ready=1. Shift register, bit counter and divider are cleared.
- Reset mid-frame: the frame is aborted with no resume. Outputs take their reset values on the next cycle.
- States:
  - IDLE: in_ready=1, ser_valid=0.
  - SHIFT: a frame is being sent.
- Accept: in_valid && in_ready at edge N loads the word. Bit 0 of the frame appears on ser_out from cycle N+1, with ser_valid=1, ser_first=1 and busy=1. Latency from accept to the first bit is 1 clock.
- Bit timing: each bit is held for exactly CLK_DIV clocks. A divider counts 0..CLK_DIV-1 and the shift occurs on the terminal count.
- Frame length: FLEN = WIDTH, or WIDTH+1 when parity is enabled.
- Frame markers: ser_first is high for every clock of the first bit. ser_last is high for every clock of bit FLEN-1.
- Bit order:
  - MSB_FIRST=1: bits go out WIDTH-1 down to 0.
  - MSB_FIRST=0: bits go out 0 up to WIDTH-1.
- in_ready in SHIFT: asserted only in the final clock of the final bit (ser_last && divider at terminal count).
  - If a word is accepted in that clock, the next frame's first bit follows on the next clock with no idle gap. busy stays 1 and the block stays in SHIFT.
  - Otherwise the block returns to IDLE. On the next clock ser_valid=0, busy=0 and ser_out=0.
- in_valid while in_ready=0 is ignored. The producer must hold data_in and in_valid until accepted.
- data_in is sampled only at accept. Changes to data_in mid-frame have no effect.
- Sizing: the bit counter is $clog2(FLEN+1) bits wide and the divider is $clog2(CLK_DIV+1) bits wide. Neither wraps within a frame.

Optional Feature:
PISO_PARITY_EN
- Defined: one parity bit is appended after the data bits. Its value is ^data for PARITY_ODD=0 (even) and ~^data for PARITY_ODD=1 (odd). ser_last marks the parity bit, and FLEN=WIDTH+1.
- Undefined: no parity logic is built, PARITY_ODD is ignored, and FLEN=WIDTH.

Test Plan:
- WIDTH=4, MSB_FIRST=1, CLK_DIV=1; reset then accept 4'b1011 -> ser_out = 1,0,1,1 on cycles N+1..N+4; ser_first only at N+1, ser_last only at N+4; at N+5 ser_valid=0 and in_ready=1.
- WIDTH=4, MSB_FIRST=0, accept 4'b1011 -> ser_out = 1,1,0,1; busy=1 for exactly 4 clocks.
- Back-to-back: in_valid held high with 4'hB then 4'h6 (MSB first) -> continuous stream 1,0,1,1,0,1,1,0 with ser_valid never dropping; in_ready high only on the 4th bit of frame 1.
- CLK_DIV=3, WIDTH=4, accept 4'b1001 -> each bit held 3 clocks (12 valid clocks total); in_ready stays 0 through the frame until its last clock; a new word offered mid-frame is not accepted.
- Reset mid-frame: assert rst during the 2nd bit of 4'b1011 -> next cycle all outputs 0 and in_ready=1; a fresh accept of 4'b0110 sends 0,1,1,0 cleanly.
- With PISO_PARITY_EN, WIDTH=4, PARITY_ODD=0, accept 4'b1011 -> 5 bits 1,0,1,1,1 with ser_last on the parity bit; with PARITY_ODD=1 the 5th bit is 0.
